// File: rtl/branch_pkg.sv
// branch_pkg: RV32I branch opcodes, condition codes, BHT counter states and immediate decoders.
package branch_pkg;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_e;

    typedef logic [1:0] bht_cnt_t;
    localparam bht_cnt_t SNT = 2'b00;
    localparam bht_cnt_t WNT = 2'b01;
    localparam bht_cnt_t WT  = 2'b10;
    localparam bht_cnt_t ST  = 2'b11;

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction
endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: array of 2-bit saturating counters with a combinational read port and one train port.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    bht_cnt_t cnt [DEPTH];
    bht_cnt_t cur;

    assign rd_taken = cnt[rd_idx][1];
    assign cur      = cnt[wr_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) cnt[k] <= WNT;
        end else if (wr_en) begin
            cnt[wr_idx] <= wr_taken ? (cur == ST ? ST : cur + 2'd1)
                                    : (cur == SNT ? SNT : cur - 2'd1);
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: RV32I branch/jump resolution with registered redirect/flush and a 2-bit BHT predictor.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [31:0]       ex_instr,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_r1,
    input  logic [XLEN-1:0]   ex_r2,
    input  logic              ex_pred_taken,
    output logic              br_taken_o,
    output logic [XLEN-1:0]   br_target_o,
    output logic              br_flush_o,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [6:0]      opcode;
    br_cond_e        cond_code;
    logic            is_br, is_jal, is_jalr, cond, taken, flush, eq, lt, ltu, unused_pc;
    logic [XLEN-1:0] imm, sum, target;

    assign opcode    = ex_instr[6:0];
    assign cond_code = br_cond_e'(ex_instr[14:12]);
    // funct3 010/011 are not branches at all
    assign is_br     = ex_valid && opcode == OP_BRANCH && ex_instr[14:13] != 2'b01;
    assign is_jal    = ex_valid && opcode == OP_JAL;
    assign is_jalr   = ex_valid && opcode == OP_JALR;
    assign eq        = ex_r1 == ex_r2;
    assign lt        = $signed(ex_r1) < $signed(ex_r2);
    assign ltu       = ex_r1 < ex_r2;
    assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    always_comb begin
        case (cond_code)
            BR_EQ:   cond = eq;
            BR_NE:   cond = !eq;
            BR_LT:   cond = lt;
            BR_GE:   cond = !lt;
            BR_LTU:  cond = ltu;
            BR_GEU:  cond = !ltu;
            default: cond = 1'b0;
        endcase
        imm    = is_jal  ? XLEN'($signed(imm_j(ex_instr)))
               : is_jalr ? XLEN'($signed(imm_i(ex_instr)))
               :           XLEN'($signed(imm_b(ex_instr)));
        sum    = (is_jalr ? ex_r1 : ex_pc) + imm;
        taken  = is_jal || is_jalr || (is_br && cond);
        target = taken ? {sum[XLEN-1:1], sum[0] & !is_jalr} : ex_pc + XLEN'(4);
        flush  = is_br ? taken != ex_pred_taken : is_jal ? !ex_pred_taken : is_jalr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_taken_o       <= 1'b0;
            br_target_o      <= '0;
            br_flush_o       <= 1'b0;
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            br_taken_o       <= taken;
            br_target_o      <= target;
            br_flush_o       <= flush;
            perf_branches    <= perf_branches + PERF_W'(is_br);
            perf_mispredicts <= perf_mispredicts + PERF_W'(flush);
        end
    end

    bht_2bit #(.DEPTH(BHT_DEPTH)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_taken (if_pred_taken),
        .wr_en    (is_br),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and random stimulus against a behavioural branch/BHT reference model.
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_instr, ex_pc, ex_r1, ex_r2;
    logic        ex_pred_taken;
    logic        br_taken_o, br_flush_o;
    logic [31:0] br_target_o, perf_branches, perf_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    int          m_bht [64];
    logic [31:0] m_br, m_mis, e_tg;
    logic        e_tk, e_fl;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_r1(ex_r1), .ex_r2(ex_r2),
        .ex_pred_taken(ex_pred_taken), .br_taken_o(br_taken_o), .br_target_o(br_target_o),
        .br_flush_o(br_flush_o), .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] im);
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im);
        return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_jr(input logic [11:0] im);
        return {im, 5'd1, 3'b000, 5'd1, 7'h67};
    endfunction

    task automatic model(input logic rs, input logic v, input logic [31:0] ins, pc, a, b, input logic pr);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] bi, ji, ii, tg;
        logic        is_b, is_j, is_r, c, tk;
        int          ix;
        if (!rs) begin
            for (int k = 0; k < 64; k++) m_bht[k] = 1;
            m_br = 0; m_mis = 0; e_tk = 0; e_fl = 0; e_tg = 0;
            return;
        end
        op   = ins[6:0];
        f3   = ins[14:12];
        is_b = v && op == 7'h63 && f3 != 3'd2 && f3 != 3'd3;
        is_j = v && op == 7'h6f;
        is_r = v && op == 7'h67;
        case (f3)
            3'd0:    c = a == b;
            3'd1:    c = a != b;
            3'd4:    c = $signed(a) < $signed(b);
            3'd5:    c = $signed(a) >= $signed(b);
            3'd6:    c = a < b;
            default: c = a >= b;
        endcase
        bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ii = {{20{ins[31]}}, ins[31:20]};
        tk = is_j || is_r || (is_b && c);
        tg = is_r ? ((a + ii) & ~32'd1) : is_j ? pc + ji : pc + bi;
        e_tk = tk;
        e_tg = tk ? tg : pc + 4;
        e_fl = is_b ? (tk != pr) : is_j ? !pr : is_r;
        if (is_b) begin
            m_br++;
            ix = int'(pc[7:2]);
            m_bht[ix] = tk ? (m_bht[ix] == 3 ? 3 : m_bht[ix] + 1) : (m_bht[ix] == 0 ? 0 : m_bht[ix] - 1);
        end
        if (e_fl) m_mis++;
    endtask

    task automatic cyc(input logic rs, input logic v, input logic [31:0] ins, pc, a, b,
                       input logic pr, input logic [31:0] ipc);
        rst_n = rs; ex_valid = v; ex_instr = ins; ex_pc = pc; ex_r1 = a; ex_r2 = b;
        ex_pred_taken = pr; if_pc = ipc;
        #1 check("if_pred", 32'(if_pred_taken), 32'(m_bht[int'(ipc[7:2])] >= 2));
        model(rs, v, ins, pc, a, b, pr);
        @(posedge clk);
        #1;
        check("taken", 32'(br_taken_o), 32'(e_tk));
        check("target", br_target_o, e_tg);
        check("flush", 32'(br_flush_o), 32'(e_fl));
        check("perf_br", perf_branches, m_br);
        check("perf_mis", perf_mispredicts, m_mis);
    endtask

    initial begin
        logic [31:0] ins, pc, a, b;
        logic [2:0]  f3;
        int          kind;
        for (int k = 0; k < 64; k++) m_bht[k] = 1;
        m_br = 0; m_mis = 0;
        rst_n = 0; ex_valid = 1; ex_instr = enc_j(21'd8); ex_pc = 32'h40; ex_r1 = 0; ex_r2 = 0;
        ex_pred_taken = 0; if_pc = 0;
        @(posedge clk);
        #1;
        cyc(0, 1, enc_b(3'd0, 13'd16), 32'h100, 5, 5, 0, 32'h0);
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'hFC);
        cyc(1, 1, enc_b(3'd0, 13'd16), 32'h100, 5, 5, 0, 32'h100);
        cyc(1, 0, 32'h0, 32'h200, 0, 0, 0, 32'h100);
        cyc(1, 1, enc_b(3'd4, 13'd32), 32'h300, 32'hFFFF_FFFF, 1, 1, 32'h300);
        for (int k = 0; k < 5; k++)
            cyc(1, 1, enc_b(3'd6, 13'd32), 32'h300, 32'hFFFF_FFFF, 1, 0, 32'h300);
        cyc(1, 1, enc_jr(12'd4), 32'h400, 32'h203, 0, 1, 32'h400);
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h400);
        cyc(1, 1, enc_b(3'd1, 13'h1FF0), 32'hC, 1, 2, 0, 32'hC);
        cyc(1, 1, enc_b(3'd1, 13'h1FF0), 32'hC, 1, 2, 1, 32'hC);
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'hC);
        cyc(1, 1, enc_j(21'h1FFFF0), 32'h8, 0, 0, 1, 32'h8);
        cyc(1, 1, enc_b(3'd5, 13'd64), 32'hFFFF_FFF0, 3, 3, 0, 32'h0);
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
            b    = $urandom_range(0, 3) == 0 ? a : $urandom;
            pc   = $urandom_range(0, 7) == 0 ? $urandom & ~32'd3 : 32'($urandom_range(0, 1023)) & ~32'd3;
            ins  = kind < 6 ? enc_b(f3, 13'($urandom)) : kind == 6 ? enc_j(21'($urandom))
                 : kind == 7 ? enc_jr(12'($urandom)) : $urandom;
            cyc(1, $urandom_range(0, 4) != 0, ins, pc, a, b, 1'($urandom), 32'($urandom_range(0, 1023)));
        end
        cyc(1, 1, enc_j(21'd16), 32'h500, 0, 0, 0, 32'h0);
        check("flush_pulse", 32'(br_flush_o), 32'd1);
        cyc(0, 1, enc_b(3'd0, 13'd16), 32'h100, 7, 7, 0, 32'h0);
        for (int k = 0; k < 64; k++)
            cyc(1, 0, 32'h0, 32'(k * 4), 0, 0, 0, 32'(k * 4));
        cyc(1, 1, enc_b(3'd2, 13'd16), 32'h100, 5, 5, 1, 32'h100);
        cyc(1, 1, enc_b(3'd3, 13'd16), 32'h100, 5, 6, 0, 32'h100);
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
